data_mem_responder: RTL
=======================

# data_mem_responder

Responder end of the processor's data-memory request interface. It accepts one load or store at a time from the processor-side initiator over a valid/ready request channel and performs it against a word-addressed on-chip RAM. After a programmable number of wait states, it returns completion on a valid/ready response channel. The block replaces the single-cycle data memory when the datapath moves to a handshaked memory port.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words; legal word addresses are 0..DEPTH-1.
- AW, 32: request address width. Addresses are word indices, not byte addresses.
- LATENCY, 2: wait-state cycles between acceptance and response; legal range 0..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  initiator has a request.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  AW  word address.
- req_wdata  in  32  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  initiator takes the response.
- resp_rdata  out  32  load data; 0 for stores and for errors.
- resp_err  out  1  request address was at or above DEPTH.

## Operation
- FSM states:
  - IDLE: req_ready=1. On req_valid, accept the request, capture write/addr/wdata, then go to WAIT, or go to RESP if LATENCY=0.
  - WAIT: a down-counter loaded with LATENCY-1 decrements each cycle. At 0, go to RESP.
  - RESP: resp_valid=1. Hold resp_rdata and resp_err stable until resp_ready=1, then go to IDLE.
- Store, in range: the RAM write commits on the acceptance edge. The response carries resp_rdata=0 and resp_err=0.
- Load, in range: the RAM is read from the captured address. resp_rdata reflects the RAM contents as of the acceptance edge.
- Out of range (addr >= DEPTH): no RAM access, no write. The response carries resp_err=1 and resp_rdata=0.
- Exactly one outstanding request. A load that follows a store sees the stored value.
- Request fields are sampled only on acceptance. Later changes to them while busy are ignored.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
- RAM contents are not cleared by reset.
- Latency: a request accepted at edge N gives resp_valid=1 from the cycle after edge N+LATENCY onward.
  - LATENCY=0: resp_valid is high in the cycle right after acceptance.
- The response completes at the first edge where resp_valid and resp_ready are both 1. resp_valid drops after that edge, and req_ready rises in the same cycle.
- Back-to-back throughput: at most one request per LATENCY+2 cycles.
  - This assumes resp_ready is held at 1.
  - IDLE cannot overlap RESP.
- resp_ready while resp_valid=0 is ignored. req_valid while req_ready=0 is ignored, not queued.
- Reset mid-operation (WAIT or RESP): return to IDLE at the next edge and drop the pending response.
  - A store accepted before the reset stays committed.
- Reset in the same cycle as req_valid: reset wins and nothing is accepted.

## Structure
- Shared header `mem_defs.v` holds:
  - state encodings: IDLE=2'd0, WAIT=2'd1, RESP=2'd2; 2'd3 is illegal and recovers to IDLE;
  - response-code constants;
  - the default DEPTH/LATENCY values.
  
  The future instruction-memory responder reuses this header.
- Sub-module `dm_ram`: a DEPTH x 32 synchronous-write, registered-read array with ports clk, we, addr, wdata, rdata. It is instantiated once.
- The top level holds only the FSM, the wait counter, the request capture registers, and the range check.

## Test plan
- Reset, then idle: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0 for 5 cycles.
- Store 0xDEADBEEF to addr 5, then load addr 5, LATENCY=2, resp_ready=1:
  - each response appears 3 cycles after its acceptance;
  - the load returns 0xDEADBEEF with resp_err=0.
- Load addr 256 with DEPTH=256: resp_err=1, resp_rdata=0. A follow-up load of addr 255 shows its contents unchanged.
- Hold resp_ready=0 for 4 cycles during RESP:
  - resp_valid, resp_rdata and resp_err stay stable;
  - req_ready stays 0;
  - a second req_valid is not accepted until 1 cycle after resp_ready rises.
- LATENCY=0 build: store 0x1234 to addr 0, then load addr 0. Each response is in the cycle after acceptance, and the load returns 0x1234.
- Assert reset during WAIT of a store to addr 7 (data 0xA5A5A5A5):
  - resp_valid never rises and the FSM is back in IDLE one edge later;
  - a later load of addr 7 returns 0xA5A5A5A5.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings,
// response codes and default geometry. The instruction-memory responder
// is expected to import the same package.
package data_mem_responder_pkg;

  // 2'd3 is not a legal encoding; the FSM recovers from it to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  localparam int DEFAULT_DEPTH   = 256;
  localparam int DEFAULT_LATENCY = 2;

  // Wait-counter preload; LATENCY=0 bypasses WAIT so the value is unused there.
  function automatic logic [3:0] waitLoad(input int latency);
    return (latency == 0) ? 4'd0 : 4'(latency - 1);
  endfunction

endpackage

// File: rtl/data_mem_responder_dm_ram.sv
// DEPTH x 32 word array: synchronous write, registered read.
// A read on the same edge as a write to that word returns the old contents.
module dm_ram #(
  parameter int DEPTH = 256,
  parameter int RAW   = 8
) (
  input  logic           clk,
  input  logic           we,
  input  logic [RAW-1:0] addr,
  input  logic [31:0]    wdata,
  output logic [31:0]    rdata
);

  logic [31:0] mem [DEPTH];

  // Write on we; read data register follows the addressed word every cycle.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked responder for the processor's data-memory port.
// One request at a time: accept in IDLE, wait LATENCY cycles, present the
// response until it is taken.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | req_ready=1; a valid request is accepted on the next edge
//   ST_WAIT | counting down wait states; moves to RESP when counter is 0
//   ST_RESP | resp_valid=1; response held until resp_ready
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int AW      = 32,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err
);

  localparam int RAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = waitLoad(LATENCY);

  state_t         state;
  state_t         stateNext;
  logic           accept;
  logic [3:0]     waitCount;
  logic           capWrite;
  logic           capErr;
  logic [RAW-1:0] capAddr;
  logic           reqInRange;
  logic           ramWe;
  logic [RAW-1:0] ramAddr;
  logic [31:0]    ramRdata;

  assign reqInRange = ({1'b0, req_addr} < (AW + 1)'(DEPTH));

  // Write data goes straight to the RAM on the acceptance edge, so it never
  // needs a capture register. Reset blocks a same-cycle store.
  assign ramWe   = accept & req_write & reqInRange & ~reset;
  // While busy the RAM keeps reading the captured word, which holds the
  // registered read data stable through WAIT and RESP.
  assign ramAddr = (state == ST_IDLE) ? req_addr[RAW-1:0] : capAddr;

  dm_ram #(
    .DEPTH (DEPTH),
    .RAW   (RAW)
  ) uRam (
    .clk   (clk),
    .we    (ramWe),
    .addr  (ramAddr),
    .wdata (req_wdata),
    .rdata (ramRdata)
  );

  // Next-state and acceptance decode.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          stateNext = (LATENCY == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (waitCount == 4'd0) stateNext = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // State register, wait counter and request capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      waitCount <= 4'd0;
      capWrite  <= 1'b0;
      capErr    <= RESP_OK;
      capAddr   <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        waitCount <= WAIT_LOAD;
        capWrite  <= req_write;
        capErr    <= reqInRange ? RESP_OK : RESP_ERR;
        capAddr   <= req_addr[RAW-1:0];
      end else if ((state == ST_WAIT) && (waitCount != 4'd0)) begin
        waitCount <= waitCount - 4'd1;
      end
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = (state == ST_RESP) && (capErr == RESP_ERR);
  assign resp_rdata = ((state == ST_RESP) && !capWrite && (capErr == RESP_OK))
                      ? ramRdata : 32'd0;

endmodule
